input_dequantizer: RTL

INPUT_DEQUANTIZER -- requirements
Module: input_dequantizer

---
 rtl/input_dequantizer.sv | 118 +++++++++++
 1 files changed

// File: rtl/input_dequantizer.sv
// input_dequantizer: per-lane (x - zero_point) * scale >> frac, << shift, saturate;
// two-stage pipeline with a config FSM that drains in-flight beats before swapping config.
module input_dequantizer #(
    parameter int numElements    = 4,
    parameter int inputWidth     = 8,
    parameter int outputWidth    = 20,
    parameter int fixedPointBits = 16,
    parameter int shiftBits      = 5
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic signed [numElements-1:0][inputWidth-1:0] x_i,
    input  logic                                         in_valid_i,
    output logic                                         in_ready_o,
    output logic signed [numElements-1:0][outputWidth-1:0] y_o,
    output logic [numElements-1:0]                       sat_o,
    output logic                                         out_valid_o,
    input  logic                                         out_ready_i,
    input  logic                                         cfg_load_i,
    input  logic [fixedPointBits-1:0]                    input_scale,
    input  logic [shiftBits-1:0]                         input_shift,
    input  logic signed [inputWidth-1:0]                 zero_point,
    output logic                                         cfg_busy_o
);
    localparam int DW = inputWidth + 1;
    localparam int PW = DW + 1;
    localparam int MW = DW + fixedPointBits;
    localparam int QW = PW + (1 << shiftBits) - 1;
    localparam logic signed [QW-1:0] YMAX = QW'((64'sd1 <<< (outputWidth - 1)) - 64'sd1);
    localparam logic signed [QW-1:0] YMIN = ~YMAX;

    typedef enum logic [1:0] {UNCFG, RUN, DRAIN} state_t;

    state_t                    state_q, state_d;
    logic [fixedPointBits-1:0] scale_q;
    logic [shiftBits-1:0]      shift_q;
    logic signed [inputWidth-1:0] zp_q;
    logic                      s1_valid_q, s2_valid_q, en, accept, cap;
    logic signed [PW-1:0]      p_d [numElements];
    logic signed [PW-1:0]      p_q [numElements];
    logic [outputWidth-1:0]    y_l [numElements];
    logic                      sat_l [numElements];
    logic signed [numElements-1:0][outputWidth-1:0] y_q;
    logic [numElements-1:0]    sat_q;

    for (genvar g = 0; g < numElements; g++) begin : g_lane
        logic signed [DW-1:0] d;
        logic [DW-1:0]        mag;
        logic [MW-1:0]        prod;
        logic signed [QW-1:0] q;
        assign d    = {x_i[g][inputWidth-1], x_i[g]} - {zp_q[inputWidth-1], zp_q};
        assign mag  = d[DW-1] ? -d : d;
        assign prod = MW'(mag) * MW'(scale_q);
        // Magnitude-domain truncation keeps rounding symmetric toward zero
        assign p_d[g] = d[DW-1] ? -$signed({1'b0, prod[MW-1:fixedPointBits]})
                                : $signed({1'b0, prod[MW-1:fixedPointBits]});
        assign q        = QW'(p_q[g]) <<< shift_q;
        assign y_l[g]   = q > YMAX ? YMAX[outputWidth-1:0] : q < YMIN ? YMIN[outputWidth-1:0] : q[outputWidth-1:0];
        assign sat_l[g] = q > YMAX || q < YMIN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= UNCFG;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            UNCFG:   if (cfg_load_i) state_d = RUN;
            RUN:     if (cfg_load_i && (accept || s1_valid_q || s2_valid_q)) state_d = DRAIN;
            DRAIN:   if (!s1_valid_q && !s2_valid_q) state_d = RUN;
            default: state_d = UNCFG;
        endcase
    end

    always_comb begin
        en         = !s2_valid_q || out_ready_i;
        in_ready_o = state_q == RUN && en;
        accept     = in_valid_i && in_ready_o;
        cfg_busy_o = state_q == DRAIN;
        cap        = state_q == UNCFG ? cfg_load_i :
                     state_q == RUN   ? cfg_load_i && !accept && !s1_valid_q && !s2_valid_q :
                     state_q == DRAIN && !s1_valid_q && !s2_valid_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scale_q    <= '0;
            shift_q    <= '0;
            zp_q       <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            y_q        <= '0;
            sat_q      <= '0;
            for (int i = 0; i < numElements; i++) p_q[i] <= '0;
        end else begin
            if (cap) begin
                scale_q <= input_scale;
                shift_q <= input_shift;
                zp_q    <= zero_point;
            end
            if (en) begin
                s1_valid_q <= accept;
                s2_valid_q <= s1_valid_q;
                for (int i = 0; i < numElements; i++) begin
                    p_q[i]   <= p_d[i];
                    y_q[i]   <= y_l[i];
                    sat_q[i] <= sat_l[i];
                end
            end
        end
    end

    assign y_o         = y_q;
    assign sat_o       = sat_q;
    assign out_valid_o = s2_valid_q;
endmodule
